// File: rtl/pc_stack_unit_if.sv
// Control/status bundle for pc_stack_unit: the controller drives op/operands,
// the PC block returns the program counter, stack pointer and error flags.
interface pc_stack_unit_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;
    logic             clr_err;
    logic [WIDTH-1:0] pc;
    logic [SP_W-1:0]  sp;
    logic             stack_empty;
    logic             stack_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output en, op, target, offset, clr_err,
        input  pc, sp, stack_empty, stack_full, overflow, underflow
    );

    modport slave (
        input  en, op, target, offset, clr_err,
        output pc, sp, stack_empty, stack_full, overflow, underflow
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with SEQ/JUMP/BRANCH/CALL/RET and a LIFO return-address stack.
// All pc arithmetic wraps modulo 2^WIDTH; overflow/underflow flags are sticky.
module pc_stack_unit #(
    parameter int               WIDTH        = 8,
    parameter int               STEP         = 4,
    parameter int               STACK_DEPTH  = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_stack_unit_if.slave   bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_SEQ    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100
    } op_e;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] mem_q [STACK_DEPTH];

    logic             push_en;
    logic [WIDTH-1:0] push_data;
    logic [WIDTH-1:0] pop_data;
    logic             full;
    logic             empty;

    assign full  = (sp_q == SP_W'(STACK_DEPTH));
    assign empty = (sp_q == '0);

    // Top-of-stack read is combinational so a RET right after a CALL sees the new entry.
    always_comb begin
        pop_data = mem_q[0];
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) begin
                pop_data = mem_q[i];
            end
        end
    end

    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        push_en   = 1'b0;
        push_data = pc_q + WIDTH'(STEP);

        if (bus.clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        // Error-setting events are evaluated after the clear so that set wins.
        if (bus.en) begin
            case (bus.op)
                OP_SEQ:    pc_d = pc_q + WIDTH'(STEP);
                OP_JUMP:   pc_d = bus.target;
                OP_BRANCH: pc_d = pc_q + bus.offset;
                OP_CALL: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        pc_d    = bus.target;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d = pop_data;
                        sp_d = sp_q - SP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            pc_q  <= RESET_VECTOR;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!rst_n && push_en && (sp_q == SP_W'(i))) begin
                mem_q[i] <= push_data;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.sp          = sp_q;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.overflow    = ovf_q;
    assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit (WIDTH=8, STEP=4, DEPTH=4, RESET_VECTOR=0):
// each stimulus cycle queues its hand-computed result, a monitor pops and compares.
module tb_pc_stack_unit;
    localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BRA = 3'd2, CAL = 3'd3, RET = 3'd4, HLD = 3'd5;

    typedef struct packed {
        logic [7:0] pc;
        logic [2:0] sp;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic chk = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    string name_q[$];

    pc_stack_unit_if #(.WIDTH(8), .STACK_DEPTH(4)) bus ();

    pc_stack_unit #(
        .WIDTH(8), .STEP(4), .STACK_DEPTH(4), .RESET_VECTOR(8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input string nm, input logic r, input logic e, input logic [2:0] o,
                        input logic [7:0] t, input logic [7:0] off, input logic c,
                        input logic [7:0] epc, input logic [2:0] esp,
                        input logic eovf, input logic eunf);
        exp_t x;
        @(negedge clk);
        rst_n       = r;
        bus.en      = e;
        bus.op      = o;
        bus.target  = t;
        bus.offset  = off;
        bus.clr_err = c;
        chk         = 1'b1;
        x.pc    = epc;
        x.sp    = esp;
        x.empty = (esp == 3'd0);
        x.full  = (esp == 3'd4);
        x.ovf   = eovf;
        x.unf   = eunf;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: every edge where stimulus was flagged produces one observed result.
    initial begin
        forever begin
            logic take;
            exp_t got, want;
            string nm;
            @(posedge clk);
            take = chk;
            #1;
            if (take) begin
                checks++;
                got = {bus.pc, bus.sp, bus.stack_empty, bus.stack_full, bus.overflow, bus.underflow};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_result got pc=%h sp=%0d", got.pc, got.sp);
                end else begin
                    want = exp_q.pop_front();
                    nm   = name_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL %s got pc=%h sp=%0d e=%b f=%b ovf=%b unf=%b required pc=%h sp=%0d e=%b f=%b ovf=%b unf=%b",
                                 nm, got.pc, got.sp, got.empty, got.full, got.ovf, got.unf,
                                 want.pc, want.sp, want.empty, want.full, want.ovf, want.unf);
                    end else begin
                        $display("ok   %s pc=%h sp=%0d ovf=%b unf=%b", nm, got.pc, got.sp, got.ovf, got.unf);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.op = HLD; bus.target = '0; bus.offset = '0; bus.clr_err = 1'b0;
        //   name            rst  en  op   target off    clr  pc     sp  ovf  unf
        step("reset",        1, 1, JMP, 8'h55, 8'h00, 0, 8'h00, 0, 0, 0);
        step("jump_fc",      0, 1, JMP, 8'hFC, 8'h00, 0, 8'hFC, 0, 0, 0);
        step("seq_wrap",     0, 1, SEQ, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        step("branch_neg",   0, 1, BRA, 8'h00, 8'hF8, 0, 8'hF8, 0, 0, 0);
        step("branch_pos",   0, 1, BRA, 8'h00, 8'h0C, 0, 8'h04, 0, 0, 0);
        step("jump_10",      0, 1, JMP, 8'h10, 8'h00, 0, 8'h10, 0, 0, 0);
        step("call_40",      0, 1, CAL, 8'h40, 8'h00, 0, 8'h40, 1, 0, 0);
        step("call_50",      0, 1, CAL, 8'h50, 8'h00, 0, 8'h50, 2, 0, 0);
        step("call_60",      0, 1, CAL, 8'h60, 8'h00, 0, 8'h60, 3, 0, 0);
        step("call_70_full", 0, 1, CAL, 8'h70, 8'h00, 0, 8'h70, 4, 0, 0);
        step("call_80_ovf",  0, 1, CAL, 8'h80, 8'h00, 0, 8'h70, 4, 1, 0);
        step("ret_1",        0, 1, RET, 8'h00, 8'h00, 0, 8'h64, 3, 1, 0);
        step("ret_2",        0, 1, RET, 8'h00, 8'h00, 0, 8'h54, 2, 1, 0);
        step("ret_3",        0, 1, RET, 8'h00, 8'h00, 0, 8'h44, 1, 1, 0);
        step("ret_4",        0, 1, RET, 8'h00, 8'h00, 0, 8'h14, 0, 1, 0);
        step("jump_fc_2",    0, 1, JMP, 8'hFC, 8'h00, 0, 8'hFC, 0, 1, 0);
        step("call_wrap",    0, 1, CAL, 8'h20, 8'h00, 0, 8'h20, 1, 1, 0);
        step("ret_after_cal",0, 1, RET, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0);
        step("ret_empty",    0, 1, RET, 8'h00, 8'h00, 0, 8'h00, 0, 1, 1);
        step("clr_and_unf",  0, 1, RET, 8'h00, 8'h00, 1, 8'h00, 0, 0, 1);
        step("clr_hold",     0, 1, HLD, 8'h00, 8'h00, 1, 8'h00, 0, 0, 0);
        step("jump_30",      0, 1, JMP, 8'h30, 8'h00, 0, 8'h30, 0, 0, 0);
        step("call_a0",      0, 1, CAL, 8'hA0, 8'h00, 0, 8'hA0, 1, 0, 0);
        step("stall_1",      0, 0, CAL, 8'h99, 8'h00, 0, 8'hA0, 1, 0, 0);
        step("stall_2",      0, 0, CAL, 8'h99, 8'h00, 0, 8'hA0, 1, 0, 0);
        step("stall_3",      0, 0, CAL, 8'h99, 8'h00, 0, 8'hA0, 1, 0, 0);
        step("hold_en",      0, 1, HLD, 8'h99, 8'h00, 0, 8'hA0, 1, 0, 0);
        step("op_111_hold",  0, 1, 3'd7, 8'h99, 8'h33, 0, 8'hA0, 1, 0, 0);
        step("ret_stalled",  0, 1, RET, 8'h00, 8'h00, 0, 8'h34, 0, 0, 0);
        step("ret_empty_2",  0, 1, RET, 8'h00, 8'h00, 0, 8'h34, 0, 0, 1);
        step("clr_stalled",  0, 0, RET, 8'h00, 8'h00, 1, 8'h34, 0, 0, 0);
        step("jump_77",      0, 1, JMP, 8'h77, 8'h00, 0, 8'h77, 0, 0, 0);
        step("call_e0",      0, 1, CAL, 8'hE0, 8'h00, 0, 8'hE0, 1, 0, 0);
        step("reset_mid",    1, 1, CAL, 8'h12, 8'h00, 0, 8'h00, 0, 0, 0);
        step("ret_post_rst", 0, 1, RET, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1);
        @(negedge clk);
        chk = 1'b0;
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter block with sequential, absolute-jump, relative-branch, call and return operations. Return addresses are held in an internal LIFO stack, and stack overflow and underflow are flagged. It is the next generation of the project's tile-level program counter: width, step, stack depth and reset vector are all configurable. It sits between the instruction-fetch address port and the control decoder.

## Interface
Parameters:
- WIDTH, 8, PC and address width in bits (≥4).
- STEP, 4, sequential increment added on SEQ and used to form the return address.
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous and active-high: rst_n=1 at a rising edge resets the block. Reset has priority over all other inputs.
- en  in  1  advance enable. When 0, all state holds and op is ignored.
- op  in  3  operation: 000 SEQ, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101–111 HOLD.
- target  in  WIDTH  absolute destination for JUMP and CALL.
- offset  in  WIDTH  two's-complement displacement for BRANCH.
- clr_err  in  1  clears the sticky error flags.
- pc  out  WIDTH  current program counter (registered).
- sp  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_empty  out  1  sp==0 (combinational from sp).
- stack_full  out  1  sp==STACK_DEPTH (combinational from sp).
- overflow  out  1  sticky: a CALL was attempted while the stack was full.
- underflow  out  1  sticky: a RET was attempted while the stack was empty.

## Operation
- Reset:
  - pc=RESET_VECTOR, sp=0, overflow=0, underflow=0.
  - Stack contents are don't-care and are never observable.
- Operations, applied when en=1 and no reset:
  - SEQ: pc ← pc+STEP.
  - JUMP: pc ← target.
  - BRANCH: pc ← pc+offset.
  - CALL when not full:
    - mem[sp] ← pc+STEP, sp ← sp+1, pc ← target.
  - CALL when full:
    - No push; pc and sp hold; overflow ← 1.
  - RET when not empty:
    - pc ← mem[sp-1], sp ← sp−1.
  - RET when empty:
    - pc and sp hold; underflow ← 1.
  - HOLD: no state change.
- Arithmetic:
  - All pc arithmetic is modulo 2^WIDTH; carries are discarded.
  - BRANCH adds offset as a WIDTH-bit sum, so negative offsets work by wrap.
  - The pushed return address wraps the same way; 0xFC+4 pushes 0x00 for WIDTH=8.
- Error flags:
  - overflow and underflow are sticky until clr_err=1 or reset.
  - clr_err is honoured regardless of en.
  - If clr_err=1 and an error-setting event occur in the same cycle, set wins and the flag reads 1.
- Stall: en=0 freezes pc, sp and the stack. Error flags also hold, except for clr_err.

## Timing
- Single-cycle: the op sampled at edge N is reflected on pc, sp and the flags immediately after edge N.
- No combinational path from op, target or offset to pc.
- A RET immediately after a CALL returns the address pushed by that CALL, with no bubble.
- Reset mid-operation: any op presented in the reset cycle is discarded. The next cycle starts from the reset state.
- Back-to-back CALLs fill the stack one entry per cycle. Back-to-back RETs drain it one entry per cycle.

## Test plan
All cases use WIDTH=8, STEP=4, STACK_DEPTH=4, RESET_VECTOR=0x00.
- Reset:
  - Stimulus: rst_n=1 for one cycle with en=1, op=JUMP, target=0x55.
  - Required: pc=0x00, sp=0, stack_empty=1, overflow=0, underflow=0.
- Wrap:
  - Stimulus: JUMP target=0xFC, then SEQ.
  - Required: pc=0x00.
  - Stimulus: then BRANCH offset=0xF8.
  - Required: pc=0xF8.
- Nesting and overflow:
  - Stimulus: from pc=0x10, CALL 0x40, CALL 0x50, CALL 0x60, CALL 0x70.
  - Required: sp=4, stack_full=1.
  - Stimulus: a 5th CALL 0x80.
  - Required: pc stays 0x70, overflow=1.
  - Stimulus: then four RETs.
  - Required: pc sequence 0x64, 0x54, 0x44, 0x14; sp=0.
- Underflow and clear:
  - Stimulus: RET with sp=0.
  - Required: pc holds, underflow=1.
  - Stimulus: same-cycle clr_err=1 with another empty RET.
  - Required: underflow stays 1.
  - Stimulus: then clr_err=1 with op=HOLD.
  - Required: underflow=0.
- Stall:
  - Stimulus: en=0 with op=CALL, target=0x99 for 3 cycles.
  - Required: pc, sp and stack unchanged.
  - Stimulus: en=1 with op=HOLD.
  - Required: no change.
